tinytester_phase_engine: RTL and testbench
==========================================

# tinytester_phase_engine

Four-phase test-vector engine for the tiny tester FPGA. Sits directly downstream of the Wishbone register block: it consumes the control, dataout, output-enable and active-on-phase registers, drives the 32 DUT pins, and returns captured DUT input data plus status to the register block for software readback.

## Interface
Parameters:
- `PINS`, 32: number of DUT pins; all pin-wide buses are this width.

Ports:
- `WBs_CLK_i` in 1: the only clock.
- `WBs_RST_i` in 1: asynchronous, active-high reset.
- `control_i` in 32: control word.
  - [0] run.
  - [1] continuous.
  - [3] irq enable.
  - [15:8] phase length minus 1, in clocks.
  - [31:16] cycle count N (0 is treated as 1).
- `dataout_i` in PINS: pin drive data.
- `oe_i` in PINS: 1 = pin is an output.
- `active_on_p0_i`..`active_on_p3_i` in PINS: pin drives data during phase k.
- `pin_i` in PINS: DUT pin input values.
- `pin_o` out PINS: pin drive values.
- `pin_oe_o` out PINS: pin output enables.
- `datain_o` out PINS: captured DUT data.
- `status_o` out 32: status word.
  - [0] busy.
  - [1] done.
  - [31:16] completed-cycle count.
- `irq_o` out 1: interrupt, level.

## Operation
- FSM states: IDLE, P0, P1, P2, P3. A test cycle is P0→P1→P2→P3. Each phase lasts L = control_i[15:8]+1 clocks, from 1 to 256.
- Start: in IDLE, a rising edge of control_i[0] (run_q=0, run=1) moves the FSM to P0.
  - Clears done and the completed-cycle count.
  - Loads the cycle target N.
- Shadowing: dataout, oe and active_on_p0..p3 are copied into shadow registers on the clock that enters P0, for every cycle. Register writes mid-cycle take effect at the next cycle boundary.
- Pin drive, in phase k for pin n:
  - pin_oe_o[n] = oe_sh[n].
  - pin_o[n] = active_pk_sh[n] ? dataout_sh[n] : 0 (return-to-zero).
- In IDLE: pin_o = 0 and pin_oe_o = 0.
- Capture: on the last clock of P3, the (synchronized, see Configuration) pin_i value is written to datain_o, and the completed-cycle count increments. The count saturates at 0xFFFF.
- End of cycle (last clock of P3):
  - Go to IDLE and set done=1 if control_i[0]=0, or if continuous=0 and completed count has reached N.
  - Otherwise go to P0.
- Continuous=1: N is ignored, and the run continues until control_i[0] is cleared.
- Clearing control_i[0] mid-cycle never truncates the cycle; the current cycle always completes.
- A rising edge of control_i[0] while busy is ignored.
- irq_o = done & control_i[3]. done stays set until the next start or reset.
- Phase length is sampled at each phase entry, so a change to it takes effect at the next phase.

## Timing
- Reset values: every output is 0, FSM is IDLE, shadows are 0, and run_q is 0.
- Start latency: control_i[0] goes high at edge t → P0 outputs valid after edge t+1, and busy=1 from edge t+1.
- Pin outputs are registered and change only on the clock edge of a phase entry.
- Phase k spans exactly L clocks.
- A single cycle takes 4L clocks.
- A run of N cycles keeps busy high for 4L·N clocks.
- datain_o and the completed count update on the edge that leaves P3. done and busy=0 update on that same edge.
- Reset asserted mid-run: immediate return to IDLE, all outputs forced to 0 asynchronously.

## Configuration
- `TINYTESTER_INPUT_SYNC_EN`:
  - Defined: pin_i passes through a 2-flop synchronizer before capture. The captured value is pin_i as sampled 2 clocks before the last P3 clock.
  - Undefined: pin_i is sampled directly on the last clock of P3, with no synchronizer and no added latency.

## Test plan
- Reset: assert WBs_RST_i mid-run → all outputs, including pin_oe_o, read 0 within the same cycle; FSM returns to IDLE.
- Single cycle. Setup: control=0x0001_0301 (L=4, N=1), dataout=0xA5A5A5A5, oe=0xFFFFFFFF, active_p1=0x0000FFFF, other active registers 0. Required response:
  - pin_o = 0 in P0, P2 and P3.
  - pin_o = 0x0000A5A5 for exactly 4 clocks in P1.
  - busy high for 16 clocks, then done=1 and count=1.
- Capture. Setup: pin_i=0x12345678, N=3, L=1. Required response: datain_o=0x12345678, count=3, busy for 12 clocks. Repeat with and without the macro to confirm the capture-point difference.
- Continuous mode. Setup: control[1]=1, run held for about 10 cycles, then run cleared mid-P1. Required response: the current cycle completes through P3, then IDLE and done=1.
- Shadowing. Setup: write dataout=0xFFFFFFFF during P2 of cycle 1 of a 2-cycle run. Required response: cycle 1 pins are unchanged; cycle 2 drives the new value.
- IRQ and retrigger:
  - With control[3]=1: irq_o rises at end of run.
  - A run edge pulsed while busy → ignored.
  - A new run edge → irq_o and done clear, count restarts from 0.

Source files
------------

// File: rtl/tinytester_phase_engine_if.sv
// Register-side bundle between the Wishbone register block and the tiny tester phase engine.
//
// The register block (master) presents control, pin data, output-enable and active-on-phase
// words. The phase engine (slave) returns the captured DUT data, status word and interrupt.
//
// Signals:
//   control_i             control word (run, continuous, irq enable, phase length, cycle count)
//   dataout_i             pin drive data
//   oe_i                  pin output enables (1 = output)
//   active_on_p0_i..p3_i  per-phase drive masks
//   datain_o              captured DUT input data
//   status_o              {completed cycles[31:16], 14'b0, done, busy}
//   irq_o                 level interrupt
interface tinytester_phase_engine_if #(
  parameter int unsigned PINS = 32
);
  logic [31:0]     control_i;
  logic [PINS-1:0] dataout_i;
  logic [PINS-1:0] oe_i;
  logic [PINS-1:0] active_on_p0_i;
  logic [PINS-1:0] active_on_p1_i;
  logic [PINS-1:0] active_on_p2_i;
  logic [PINS-1:0] active_on_p3_i;
  logic [PINS-1:0] datain_o;
  logic [31:0]     status_o;
  logic            irq_o;

  modport master (
    output control_i,
    output dataout_i,
    output oe_i,
    output active_on_p0_i,
    output active_on_p1_i,
    output active_on_p2_i,
    output active_on_p3_i,
    input  datain_o,
    input  status_o,
    input  irq_o
  );

  modport slave (
    input  control_i,
    input  dataout_i,
    input  oe_i,
    input  active_on_p0_i,
    input  active_on_p1_i,
    input  active_on_p2_i,
    input  active_on_p3_i,
    output datain_o,
    output status_o,
    output irq_o
  );
endinterface

// File: rtl/tinytester_phase_engine.sv
// Four-phase test-vector engine for the tiny tester FPGA.
//
// A test cycle walks P0 -> P1 -> P2 -> P3, each phase lasting control[15:8]+1 clocks. In phase k
// a pin drives dataout when its active_on_pk bit is set and 0 otherwise (return-to-zero); output
// enables follow oe for the whole cycle. On the last clock of P3 the DUT pins are captured into
// datain and the completed-cycle count advances. A run starts on a rising edge of control[0]
// while idle and ends after N cycles, or, in continuous mode, at the first cycle boundary after
// control[0] drops. A cycle in progress is never truncated.
//
// Optional feature macro: TINYTESTER_INPUT_SYNC_EN
//   defined   - pin_i passes through a 2-flop synchronizer before capture
//   undefined - pin_i is captured directly on the last P3 clock
//
// Ports:
//   WBs_CLK_i  clock
//   WBs_RST_i  asynchronous active-high reset
//   regs       register-block bundle (slave side), see tinytester_phase_engine_if
//   pin_i      DUT pin input values
//   pin_o      registered pin drive values
//   pin_oe_o   registered pin output enables
module tinytester_phase_engine #(
  parameter int unsigned PINS = 32
) (
  input  logic                     WBs_CLK_i,
  input  logic                     WBs_RST_i,
  tinytester_phase_engine_if.slave regs,
  input  logic [PINS-1:0]          pin_i,
  output logic [PINS-1:0]          pin_o,
  output logic [PINS-1:0]          pin_oe_o
);

  typedef enum logic [2:0] {
    StIdle,
    StP0,
    StP1,
    StP2,
    StP3
  } state_e;

  // Control word fields
  logic        run;
  logic        continuous;
  logic        irq_en;
  logic [7:0]  len_cfg;
  logic [15:0] n_cfg;
  logic        unused_ctrl;

  assign run         = regs.control_i[0];
  assign continuous  = regs.control_i[1];
  assign irq_en      = regs.control_i[3];
  assign len_cfg     = regs.control_i[15:8];
  assign n_cfg       = regs.control_i[31:16];
  assign unused_ctrl = ^{regs.control_i[7:4], regs.control_i[2]};

  // State
  state_e          state;
  logic            run_q;
  logic [7:0]      phase_cnt;
  logic [7:0]      phase_len;
  logic [15:0]     cycle_cnt;
  logic [15:0]     cycle_target;
  logic            busy;
  logic            done;
  logic [PINS-1:0] dataout_sh;
  logic [PINS-1:0] act_p1_sh;
  logic [PINS-1:0] act_p2_sh;
  logic [PINS-1:0] act_p3_sh;
  logic [PINS-1:0] datain_q;
  logic [PINS-1:0] pin_q;
  logic [PINS-1:0] pin_oe_q;

  // Value presented to the capture register on the last P3 clock
  logic [PINS-1:0] capture_val;

`ifdef TINYTESTER_INPUT_SYNC_EN
  logic [PINS-1:0] sync1;
  logic [PINS-1:0] sync2;

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pin_i;
      sync2 <= sync1;
    end
  end

  assign capture_val = sync2;
`else
  assign capture_val = pin_i;
`endif

  // Decoded conditions
  logic        start;
  logic        phase_last;
  logic [15:0] cycle_cnt_inc;
  logic        run_end;

  assign start         = run & ~run_q;
  assign phase_last    = (phase_cnt == phase_len);
  assign cycle_cnt_inc = (cycle_cnt == 16'hFFFF) ? cycle_cnt : cycle_cnt + 16'd1;
  // Evaluated on the last P3 clock: uses the count including the cycle just finishing.
  assign run_end       = ~run | (~continuous & (cycle_cnt_inc >= cycle_target));

  // Main FSM. The P0 drive pattern is formed straight from the register inputs on the edge that
  // enters P0, so only the data and the P1..P3 masks need shadow copies; pin_oe_q itself holds
  // the output-enable shadow for the whole cycle.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state        <= StIdle;
      run_q        <= 1'b0;
      phase_cnt    <= '0;
      phase_len    <= '0;
      cycle_cnt    <= '0;
      cycle_target <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dataout_sh   <= '0;
      act_p1_sh    <= '0;
      act_p2_sh    <= '0;
      act_p3_sh    <= '0;
      datain_q     <= '0;
      pin_q        <= '0;
      pin_oe_q     <= '0;
    end else begin
      run_q <= run;
      case (state)
        StIdle: begin
          if (start) begin
            state        <= StP0;
            phase_cnt    <= '0;
            phase_len    <= len_cfg;
            cycle_cnt    <= '0;
            cycle_target <= (n_cfg == 16'd0) ? 16'd1 : n_cfg;
            busy         <= 1'b1;
            done         <= 1'b0;
            dataout_sh   <= regs.dataout_i;
            act_p1_sh    <= regs.active_on_p1_i;
            act_p2_sh    <= regs.active_on_p2_i;
            act_p3_sh    <= regs.active_on_p3_i;
            pin_q        <= regs.dataout_i & regs.active_on_p0_i;
            pin_oe_q     <= regs.oe_i;
          end
        end
        default: begin
          if (!phase_last) begin
            phase_cnt <= phase_cnt + 8'd1;
          end else begin
            phase_cnt <= '0;
            // Phase length is resampled at every phase entry.
            phase_len <= len_cfg;
            unique case (state)
              StP0: begin
                state <= StP1;
                pin_q <= dataout_sh & act_p1_sh;
              end
              StP1: begin
                state <= StP2;
                pin_q <= dataout_sh & act_p2_sh;
              end
              StP2: begin
                state <= StP3;
                pin_q <= dataout_sh & act_p3_sh;
              end
              default: begin
                datain_q  <= capture_val;
                cycle_cnt <= cycle_cnt_inc;
                if (run_end) begin
                  state    <= StIdle;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  pin_q    <= '0;
                  pin_oe_q <= '0;
                end else begin
                  state      <= StP0;
                  dataout_sh <= regs.dataout_i;
                  act_p1_sh  <= regs.active_on_p1_i;
                  act_p2_sh  <= regs.active_on_p2_i;
                  act_p3_sh  <= regs.active_on_p3_i;
                  pin_q      <= regs.dataout_i & regs.active_on_p0_i;
                  pin_oe_q   <= regs.oe_i;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign pin_o         = pin_q;
  assign pin_oe_o      = pin_oe_q;
  assign regs.datain_o = datain_q;
  assign regs.status_o = {cycle_cnt, 14'd0, done, busy};
  // Level interrupt; follows the enable bit immediately.
  assign regs.irq_o    = done & irq_en;

endmodule

// File: tb/tb_tinytester_phase_engine.sv
// Self-checking bench for tinytester_phase_engine. Expected pin waveforms, status and capture
// values come from a timeline model: clock i of a run lies in cycle i/(4L), phase (i/L)%4.
module tb_tinytester_phase_engine;
  localparam int unsigned PINS = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [PINS-1:0] pin_in;
  logic [PINS-1:0] pin_out;
  logic [PINS-1:0] pin_oe;

  tinytester_phase_engine_if #(.PINS(PINS)) bus ();

  tinytester_phase_engine #(.PINS(PINS)) dut (
    .WBs_CLK_i (clk),
    .WBs_RST_i (rst),
    .regs      (bus),
    .pin_i     (pin_in),
    .pin_o     (pin_out),
    .pin_oe_o  (pin_oe)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_datain;
  logic [31:0] act [4];

  task automatic load_regs(input logic [31:0] d, input logic [31:0] o);
    bus.dataout_i      = d;
    bus.oe_i           = o;
    bus.active_on_p0_i = act[0];
    bus.active_on_p1_i = act[1];
    bus.active_on_p2_i = act[2];
    bus.active_on_p3_i = act[3];
  endtask

  task automatic randomize_act();
    for (int k = 0; k < 4; k++) act[k] = $urandom;
  endtask

  task automatic go_idle();
    bus.control_i = 32'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pin_out !== 32'd0 || pin_oe !== 32'd0 || bus.datain_o !== 32'd0 ||
        bus.status_o !== 32'd0 || bus.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pin_o=%h pin_oe=%h datain=%h status=%h irq=%b, want all 0",
               pin_out, pin_oe, bus.datain_o, bus.status_o, bus.irq_o);
    end
  endtask

  task automatic test_single_cycle();
    logic [31:0] want_pin;
    act[0] = 32'd0; act[1] = 32'h0000FFFF; act[2] = 32'd0; act[3] = 32'd0;
    load_regs(32'hA5A5A5A5, 32'hFFFFFFFF);
    pin_in = $urandom;
    bus.control_i = 32'h0001_0301;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      want_pin = (i / 4 == 1) ? 32'h0000A5A5 : 32'd0;
      checks++;
      if (pin_out !== want_pin || pin_oe !== 32'hFFFFFFFF || bus.status_o[1:0] !== 2'b01) begin
        errors++;
        $display("FAIL single_cycle clk %0d: pin_o=%h pin_oe=%h status=%h, want pin_o=%h oe=ffffffff busy=1",
                 i, pin_out, pin_oe, bus.status_o, want_pin);
      end
    end
    @(negedge clk);
    exp_datain = pin_in;
    checks++;
    if (bus.status_o !== 32'h0001_0002 || pin_out !== 32'd0 || pin_oe !== 32'd0 ||
        bus.datain_o !== exp_datain) begin
      errors++;
      $display("FAIL single_cycle_end: status=%h pin_o=%h pin_oe=%h datain=%h, want 00010002 0 0 %h",
               bus.status_o, pin_out, pin_oe, bus.datain_o, exp_datain);
    end
    go_idle();
  endtask

  task automatic test_capture();
    logic [31:0] pv [13];
    logic [31:0] want_status;
    randomize_act();
    load_regs($urandom, $urandom);
    pin_in = 32'h12345678;
    bus.control_i = 32'h0003_0001;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0 && i % 4 == 0) begin
`ifdef TINYTESTER_INPUT_SYNC_EN
        exp_datain = pv[i-3];
`else
        exp_datain = pv[i-1];
`endif
      end
      want_status = (i < 12) ? {16'(i / 4), 16'h0001} : 32'h0003_0002;
      checks++;
      if (bus.status_o !== want_status || bus.datain_o !== exp_datain) begin
        errors++;
        $display("FAIL capture clk %0d: status=%h datain=%h, want status=%h datain=%h",
                 i, bus.status_o, bus.datain_o, want_status, exp_datain);
      end
      pv[i] = (i == 0) ? 32'h12345678 : $urandom;
      pin_in = pv[i];
    end
    go_idle();
  endtask

  task automatic test_continuous();
    logic [31:0] d, o, want_pin, want_oe, want_status;
    randomize_act();
    d = $urandom; o = $urandom;
    load_regs(d, o);
    pin_in = $urandom;
    bus.control_i = 32'h0001_0103;
    for (int i = 0; i <= 80; i++) begin
      @(negedge clk);
      if (i > 0 && i % 8 == 0) exp_datain = pin_in;
      if (i < 80) begin
        want_status = {16'(i / 8), 16'h0001};
        want_pin    = d & act[(i / 2) % 4];
        want_oe     = o;
      end else begin
        want_status = 32'h000A_0002;
        want_pin    = 32'd0;
        want_oe     = 32'd0;
      end
      checks++;
      if (bus.status_o !== want_status || pin_out !== want_pin || pin_oe !== want_oe ||
          bus.datain_o !== exp_datain) begin
        errors++;
        $display("FAIL continuous clk %0d: status=%h pin_o=%h oe=%h datain=%h, want %h %h %h %h",
                 i, bus.status_o, pin_out, pin_oe, bus.datain_o, want_status, want_pin, want_oe,
                 exp_datain);
      end
      if (i == 74) bus.control_i = 32'h0001_0102;
    end
    go_idle();
  endtask

  task automatic test_shadow();
    logic [31:0] d0, o, want_pin, want_status;
    randomize_act();
    d0 = $urandom & 32'h7FFF_FFFF;
    o  = $urandom;
    load_regs(d0, o);
    pin_in = $urandom;
    bus.control_i = 32'h0002_0101;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0 && i % 8 == 0) exp_datain = pin_in;
      if (i < 16) begin
        want_pin    = ((i < 8) ? d0 : 32'hFFFFFFFF) & act[(i / 2) % 4];
        want_status = {16'(i / 8), 16'h0001};
      end else begin
        want_pin    = 32'd0;
        want_status = 32'h0002_0002;
      end
      checks++;
      if (pin_out !== want_pin || bus.status_o !== want_status) begin
        errors++;
        $display("FAIL shadow clk %0d: pin_o=%h status=%h, want pin_o=%h status=%h",
                 i, pin_out, bus.status_o, want_pin, want_status);
      end
      if (i == 4) bus.dataout_i = 32'hFFFFFFFF;
    end
    go_idle();
  endtask

  task automatic test_random_runs();
    int unsigned len, n, neff, plen, total;
    logic        ien, want_irq;
    logic [31:0] d, o, want_pin, want_oe, want_status;
    for (int r = 0; r < 7; r++) begin
      len   = (r == 0) ? 255 : $urandom_range(0, 3);
      n     = (r == 1) ? 0 : $urandom_range(0, 3);
      neff  = (n == 0) ? 1 : n;
      plen  = len + 1;
      total = 4 * plen * neff;
      ien   = 1'($urandom_range(0, 1));
      randomize_act();
      d = $urandom; o = $urandom;
      load_regs(d, o);
      pin_in = $urandom;
      bus.control_i = {16'(n), 8'(len), 4'd0, ien, 3'b001};
      for (int i = 0; i <= int'(total); i++) begin
        @(negedge clk);
        if (i > 0 && i % (4 * plen) == 0) exp_datain = pin_in;
        if (i < int'(total)) begin
          want_status = {16'(i / (4 * plen)), 16'h0001};
          want_pin    = d & act[(i / plen) % 4];
          want_oe     = o;
          want_irq    = 1'b0;
        end else begin
          want_status = {16'(neff), 16'h0002};
          want_pin    = 32'd0;
          want_oe     = 32'd0;
          want_irq    = ien;
        end
        checks++;
        if (bus.status_o !== want_status || pin_out !== want_pin || pin_oe !== want_oe ||
            bus.datain_o !== exp_datain || bus.irq_o !== want_irq) begin
          errors++;
          $display("FAIL random_run %0d clk %0d: status=%h pin_o=%h oe=%h datain=%h irq=%b, want %h %h %h %h %b",
                   r, i, bus.status_o, pin_out, pin_oe, bus.datain_o, bus.irq_o, want_status,
                   want_pin, want_oe, exp_datain, want_irq);
        end
      end
      go_idle();
    end
  endtask

  task automatic test_irq_retrigger();
    logic [31:0] want_status;
    logic        want_irq;
    randomize_act();
    load_regs($urandom, $urandom);
    pin_in = $urandom;
    bus.control_i = 32'h0002_0009;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      want_status = (i < 8) ? {16'(i / 4), 16'h0001} : 32'h0002_0002;
      want_irq    = (i == 8);
      checks++;
      if (bus.status_o !== want_status || bus.irq_o !== want_irq) begin
        errors++;
        $display("FAIL irq_run clk %0d: status=%h irq=%b, want status=%h irq=%b",
                 i, bus.status_o, bus.irq_o, want_status, want_irq);
      end
      if (i == 0) bus.control_i = 32'h0002_0008;
      if (i == 1) bus.control_i = 32'h0002_0009;
    end
    exp_datain = pin_in;
    bus.control_i = 32'h0002_0001;
    #1;
    checks++;
    if (bus.irq_o !== 1'b0 || bus.status_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL irq_enable_off: irq=%b done=%b, want irq=0 done=1", bus.irq_o, bus.status_o[1]);
    end
    @(negedge clk);
    bus.control_i = 32'h0002_0008;
    @(negedge clk);
    checks++;
    if (bus.irq_o !== 1'b1 || bus.status_o !== 32'h0002_0002) begin
      errors++;
      $display("FAIL irq_held: irq=%b status=%h, want irq=1 status=00020002", bus.irq_o, bus.status_o);
    end
    bus.control_i = 32'h0002_0009;
    @(negedge clk);
    checks++;
    if (bus.irq_o !== 1'b0 || bus.status_o !== 32'h0000_0001) begin
      errors++;
      $display("FAIL retrigger: irq=%b status=%h, want irq=0 status=00000001", bus.irq_o, bus.status_o);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (bus.status_o !== 32'h0002_0002 || bus.irq_o !== 1'b1) begin
      errors++;
      $display("FAIL retrigger_end: status=%h irq=%b, want 00020002 irq=1", bus.status_o, bus.irq_o);
    end
    go_idle();
  endtask

  task automatic test_reset_mid_run();
    for (int k = 0; k < 4; k++) act[k] = 32'hFFFFFFFF;
    load_regs(32'hFFFF0000 | $urandom, 32'hFFFFFFFF);
    pin_in = $urandom;
    bus.control_i = 32'h0005_0309;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.status_o[0] !== 1'b1 || pin_oe !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL reset_precondition: status=%h pin_oe=%h, want busy=1 oe=ffffffff",
               bus.status_o, pin_oe);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (pin_out !== 32'd0 || pin_oe !== 32'd0 || bus.datain_o !== 32'd0 ||
        bus.status_o !== 32'd0 || bus.irq_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pin_o=%h pin_oe=%h datain=%h status=%h irq=%b, want all 0",
               pin_out, pin_oe, bus.datain_o, bus.status_o, bus.irq_o);
    end
    bus.control_i = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (pin_out !== 32'd0 || pin_oe !== 32'd0 || bus.status_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle: pin_o=%h pin_oe=%h status=%h, want all 0",
               pin_out, pin_oe, bus.status_o);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.control_i = 32'd0;
    for (int k = 0; k < 4; k++) act[k] = 32'd0;
    load_regs(32'd0, 32'd0);
    pin_in     = 32'd0;
    exp_datain = 32'd0;
    test_reset();
    test_single_cycle();
    test_capture();
    test_continuous();
    test_shadow();
    test_random_runs();
    test_irq_retrigger();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1);
  end

endmodule
